// File: rtl/phold_pkg.sv
// Shared definitions for the phold MC lane arbiter: rtnctl field layout,
// MC command encodings, the stats select width and the held MC request record.
package phold_pkg;

  localparam int TAG_LSB    = 0;
  localparam int ID_W       = 3;
  localparam int STAT_SEL_W = 3;

  localparam logic [2:0] AEMC_CMD_IDLE = 3'd0;
  localparam logic [2:0] AEMC_CMD_RD8  = 3'd1;
  localparam logic [2:0] AEMC_CMD_WR8  = 3'd2;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
  } mc_req_t;

  // Requester id sits directly above the requester-private tag.
  function automatic int id_lsb(input int tag_w);
    return TAG_LSB + tag_w;
  endfunction

endpackage

// File: rtl/phold_mc_arb_if.sv
// Requester-side and MC-side bundles of the phold MC arbiter.
// Requester side: requesters are master, arbiter is slave. MC side: arbiter is master.
interface phold_mc_arb_req_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [3*NUM_REQ-1:0]     req_cmd;
  logic [4*NUM_REQ-1:0]     req_scmd;
  logic [2*NUM_REQ-1:0]     req_size;
  logic [48*NUM_REQ-1:0]    req_vadr;
  logic [64*NUM_REQ-1:0]    req_data;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_gnt;
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [2:0]               rsp_cmd;
  logic [63:0]              rsp_data;
  logic [TAG_W-1:0]         rsp_tag;
  logic [NUM_REQ-1:0]       rsp_stall;

  modport master (
    output req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_tag, rsp_stall,
    input  req_gnt, rsp_vld, rsp_cmd, rsp_data, rsp_tag
  );
  modport slave (
    input  req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_tag, rsp_stall,
    output req_gnt, rsp_vld, rsp_cmd, rsp_data, rsp_tag
  );
endinterface

interface phold_mc_arb_mc_if #(
  parameter int RTNCTL_WIDTH = 32
);
  logic                    mc_rq_vld;
  logic [2:0]              mc_rq_cmd;
  logic [3:0]              mc_rq_scmd;
  logic [1:0]              mc_rq_size;
  logic [47:0]             mc_rq_vadr;
  logic [63:0]             mc_rq_data;
  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic                    mc_rq_stall;
  logic                    mc_rs_vld;
  logic [2:0]              mc_rs_cmd;
  logic [3:0]              mc_rs_scmd;
  logic [63:0]             mc_rs_data;
  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic                    mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    output mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl
  );
  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    input  mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl
  );
endinterface

// File: rtl/phold_rr_arb.sv
// Round-robin one-hot arbiter: grants the first request at or after ptr+1 and
// moves the pointer to the winner. Reusable by the event-queue scheduler.
module phold_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_cand;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    o_gnt   = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found) o_gnt[w_idx] = 1'b1;
  end

  assign o_any = w_found;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_ptr <= PW'(N - 1);
    else if (w_found) r_ptr <= w_idx;
  end

endmodule

// File: rtl/phold_mc_arb.sv
// Shares one AE MC lane between NUM_REQ phold requesters with credit throttling
// and id-steered responses. Define PHOLD_MC_ARB_STATS_EN for grant/stall counters.
module phold_mc_arb
  import phold_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int TAG_W        = 8,
  parameter int MAX_OUTST    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  phold_mc_arb_req_if.slave  req,
  phold_mc_arb_mc_if.master  mc,
  output logic               idle,
  output logic               err_bad_id
`ifdef PHOLD_MC_ARB_STATS_EN
  ,
  input  logic [STAT_SEL_W-1:0] stat_sel,
  output logic [31:0]           stat_data
`endif
);
  localparam int ID_LSB = id_lsb(TAG_W);
  localparam int OW     = 8;

  logic [NUM_REQ-1:0]      w_gnt;
  logic                    w_any_gnt;
  logic                    w_slot_free, w_xfer, w_can_grant;
  mc_req_t                 w_nxt_req, r_rq;
  logic [RTNCTL_WIDTH-1:0] w_nxt_rtnctl, r_rq_rtnctl;
  logic                    r_rq_vld;
  logic [OW-1:0]           r_outst;
  logic                    w_rs_acc, w_dec, w_rs_bad, w_drain, w_sel_stall;
  logic [ID_W-1:0]         w_rs_id, r_rsp_id;
  logic                    r_rsp_held, r_mc_rs_stall, r_err;
  logic [2:0]              r_rsp_cmd;
  logic [63:0]             r_rsp_data;
  logic [TAG_W-1:0]        r_rsp_tag;
  logic [NUM_REQ-1:0]      w_rsp_vld;
  logic                    w_unused_ok;

  assign w_slot_free = !r_rq_vld || !mc.mc_rq_stall;
  assign w_xfer      = r_rq_vld && !mc.mc_rq_stall;
  // A request already sitting in the slot counts against the credit budget.
  assign w_can_grant = w_slot_free &&
                       (({1'b0, r_outst} + (OW+1)'(r_rq_vld)) < (OW+1)'(MAX_OUTST));

  phold_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (req.req_vld),
    .i_en  (w_can_grant),
    .o_gnt (w_gnt),
    .o_any (w_any_gnt)
  );

  always_comb begin
    w_nxt_req    = '0;
    w_nxt_rtnctl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_nxt_req.cmd  = req.req_cmd[i*3 +: 3];
        w_nxt_req.scmd = req.req_scmd[i*4 +: 4];
        w_nxt_req.size = req.req_size[i*2 +: 2];
        w_nxt_req.vadr = req.req_vadr[i*48 +: 48];
        w_nxt_req.data = req.req_data[i*64 +: 64];
        w_nxt_rtnctl[TAG_LSB +: TAG_W] = req.req_tag[i*TAG_W +: TAG_W];
        w_nxt_rtnctl[ID_LSB +: ID_W]   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rq_vld    <= 1'b0;
      r_rq        <= '0;
      r_rq_rtnctl <= '0;
    end else if (w_any_gnt) begin
      r_rq_vld    <= 1'b1;
      r_rq        <= w_nxt_req;
      r_rq_rtnctl <= w_nxt_rtnctl;
    end else if (w_xfer) begin
      r_rq_vld    <= 1'b0;
    end
  end

  // Stale responses landing after reset must not wrap the counter below zero.
  assign w_rs_acc = mc.mc_rs_vld && !r_mc_rs_stall;
  assign w_dec    = w_rs_acc && ((r_outst != '0) || w_xfer);

  always_ff @(posedge clk) begin
    if (!rst_n)                r_outst <= '0;
    else if (w_xfer && !w_dec) r_outst <= r_outst + 1'b1;
    else if (!w_xfer && w_dec) r_outst <= r_outst - 1'b1;
  end

  assign w_rs_id  = mc.mc_rs_rtnctl[ID_LSB +: ID_W];
  assign w_rs_bad = {1'b0, w_rs_id} >= (ID_W+1)'(NUM_REQ);

  always_comb begin
    w_sel_stall = 1'b0;
    w_rsp_vld   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_rsp_id == ID_W'(i)) begin
        w_sel_stall  = req.rsp_stall[i];
        w_rsp_vld[i] = r_rsp_held;
      end
    end
  end

  assign w_drain = r_rsp_held && !w_sel_stall;

  // mc_rs_stall lags one cycle; the MC stall slack covers the overlap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_held    <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_cmd     <= '0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
      r_mc_rs_stall <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_rs_acc && !w_rs_bad) begin
        r_rsp_held <= 1'b1;
        r_rsp_id   <= w_rs_id;
        r_rsp_cmd  <= mc.mc_rs_cmd;
        r_rsp_data <= mc.mc_rs_data;
        r_rsp_tag  <= mc.mc_rs_rtnctl[TAG_LSB +: TAG_W];
      end else if (w_drain) begin
        r_rsp_held <= 1'b0;
      end
      if (w_rs_acc && w_rs_bad) r_err <= 1'b1;
      r_mc_rs_stall <= r_rsp_held && w_sel_stall;
    end
  end

  assign w_unused_ok = &{1'b0, mc.mc_rs_scmd, mc.mc_rs_rtnctl[RTNCTL_WIDTH-1:ID_LSB+ID_W]};

  assign req.req_gnt      = w_gnt;
  assign req.rsp_vld      = w_rsp_vld;
  assign req.rsp_cmd      = r_rsp_cmd;
  assign req.rsp_data     = r_rsp_data;
  assign req.rsp_tag      = r_rsp_tag;
  assign mc.mc_rq_vld     = r_rq_vld;
  assign mc.mc_rq_cmd     = r_rq.cmd;
  assign mc.mc_rq_scmd    = r_rq.scmd;
  assign mc.mc_rq_size    = r_rq.size;
  assign mc.mc_rq_vadr    = r_rq.vadr;
  assign mc.mc_rq_data    = r_rq.data;
  assign mc.mc_rq_rtnctl  = r_rq_rtnctl;
  assign mc.mc_rs_stall   = r_mc_rs_stall;
  assign idle             = !r_rq_vld && !r_rsp_held && (r_outst == '0);
  assign err_bad_id       = r_err;

`ifdef PHOLD_MC_ARB_STATS_EN
  logic [31:0] r_gnt_cnt [NUM_REQ];
  logic [31:0] r_stall_cnt;
  logic [31:0] r_stat_data;

  // NOTE: the counter array is flops, not RAM, so it is cleared explicitly on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_gnt_cnt[i] <= '0;
      r_stall_cnt <= '0;
      r_stat_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_gnt[i] && (r_gnt_cnt[i] != '1)) r_gnt_cnt[i] <= r_gnt_cnt[i] + 1'b1;
      if (r_rq_vld && mc.mc_rq_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      r_stat_data <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (stat_sel == STAT_SEL_W'(i)) r_stat_data <= r_gnt_cnt[i];
      if ({1'b0, stat_sel} == (STAT_SEL_W+1)'(NUM_REQ)) r_stat_data <= r_stall_cnt;
    end
  end

  assign stat_data = r_stat_data;
`endif

endmodule

// File: tb/tb_phold_mc_arb.sv
// Directed self-checking bench for phold_mc_arb: a MAX_OUTST=64 instance for the
// main paths and a MAX_OUTST=2 instance for credit throttling.
module tb_phold_mc_arb;
  import phold_pkg::*;

  localparam int NR = 4;
  localparam int RW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle, err, idle2, err2;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  phold_mc_arb_req_if #(.NUM_REQ(NR), .TAG_W(TW)) rq ();
  phold_mc_arb_req_if #(.NUM_REQ(NR), .TAG_W(TW)) rq2 ();
  phold_mc_arb_mc_if  #(.RTNCTL_WIDTH(RW))        mc ();
  phold_mc_arb_mc_if  #(.RTNCTL_WIDTH(RW))        mc2 ();

`ifdef PHOLD_MC_ARB_STATS_EN
  logic [2:0]  stat_sel = 3'd0, stat_sel2 = 3'd0;
  logic [31:0] stat_data, stat_data2;
`endif

  phold_mc_arb #(.NUM_REQ(NR), .RTNCTL_WIDTH(RW), .TAG_W(TW), .MAX_OUTST(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(rq.slave), .mc(mc.master),
    .idle(idle), .err_bad_id(err)
`ifdef PHOLD_MC_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_data(stat_data)
`endif
  );

  phold_mc_arb #(.NUM_REQ(NR), .RTNCTL_WIDTH(RW), .TAG_W(TW), .MAX_OUTST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(rq2.slave), .mc(mc2.master),
    .idle(idle2), .err_bad_id(err2)
`ifdef PHOLD_MC_ARB_STATS_EN
    , .stat_sel(stat_sel2), .stat_data(stat_data2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] cmd, input logic [47:0] vadr,
                         input logic [7:0] tag);
    rq.req_vld[i]          = 1'b1;
    rq.req_cmd[i*3 +: 3]   = cmd;
    rq.req_scmd[i*4 +: 4]  = 4'd0;
    rq.req_size[i*2 +: 2]  = 2'd3;
    rq.req_vadr[i*48 +: 48] = vadr;
    rq.req_data[i*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
    rq.req_tag[i*8 +: 8]   = tag;
  endtask

  task automatic send_rsp(input logic [31:0] rtnctl, input logic [63:0] data);
    mc.mc_rs_vld    = 1'b1;
    mc.mc_rs_cmd    = 3'd2;
    mc.mc_rs_rtnctl = rtnctl;
    mc.mc_rs_data   = data;
    step();
    mc.mc_rs_vld    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_gnt;
    int g, x;
    rq.req_vld = '0;  rq.req_cmd = '0;  rq.req_scmd = '0; rq.req_size = '0;
    rq.req_vadr = '0; rq.req_data = '0; rq.req_tag = '0;  rq.rsp_stall = '0;
    rq2.req_vld = '0;  rq2.req_cmd = '0;  rq2.req_scmd = '0; rq2.req_size = '0;
    rq2.req_vadr = '0; rq2.req_data = '0; rq2.req_tag = '0;  rq2.rsp_stall = '0;
    mc.mc_rq_stall = 1'b0;  mc.mc_rs_vld = 1'b0;  mc.mc_rs_cmd = '0;
    mc.mc_rs_scmd = '0;     mc.mc_rs_data = '0;   mc.mc_rs_rtnctl = '0;
    mc2.mc_rq_stall = 1'b0; mc2.mc_rs_vld = 1'b0; mc2.mc_rs_cmd = '0;
    mc2.mc_rs_scmd = '0;    mc2.mc_rs_data = '0;  mc2.mc_rs_rtnctl = '0;

    // Reset values
    step();
    step();
    check("rst_rq_vld",   64'(mc.mc_rq_vld), 64'd0);
    check("rst_rtnctl",   64'(mc.mc_rq_rtnctl), 64'd0);
    check("rst_gnt",      64'(rq.req_gnt), 64'd0);
    check("rst_rsp_vld",  64'(rq.rsp_vld), 64'd0);
    check("rst_rs_stall", 64'(mc.mc_rs_stall), 64'd0);
    check("rst_idle",     64'(idle), 64'd1);
    check("rst_err",      64'(err), 64'd0);
    rst_n = 1'b1;
    step();

    // Single requester 1, RD8, tag 0x5A
    set_req(1, AEMC_CMD_RD8, 48'h1000, 8'h5A);
    #1;
    check("t1_gnt", 64'(rq.req_gnt), 64'h2);
    check("t1_rq_vld_pre", 64'(mc.mc_rq_vld), 64'd0);
    step();
    rq.req_vld = '0;
    check("t1_rq_vld",  64'(mc.mc_rq_vld), 64'd1);
    check("t1_rtnctl",  64'(mc.mc_rq_rtnctl), 64'h15A);
    check("t1_vadr",    64'(mc.mc_rq_vadr), 64'h1000);
    check("t1_cmd",     64'(mc.mc_rq_cmd), 64'(AEMC_CMD_RD8));
    step();
    check("t1_rq_done", 64'(mc.mc_rq_vld), 64'd0);
    check("t1_busy",    64'(idle), 64'd0);
    send_rsp(32'h15A, 64'h1122_3344_5566_7788);
    check("t1_rsp_vld",  64'(rq.rsp_vld), 64'h2);
    check("t1_rsp_tag",  64'(rq.rsp_tag), 64'h5A);
    check("t1_rsp_data", rq.rsp_data, 64'h1122_3344_5566_7788);
    step();
    check("t1_rsp_gone", 64'(rq.rsp_vld), 64'd0);
    check("t1_idle",     64'(idle), 64'd1);

    // Round-robin with all four requesters active
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AEMC_CMD_RD8, 48'h100 * i, 8'(i));
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_gnt = 4'b0001 << (k % 4);
      check($sformatf("rr_gnt%0d", k), 64'(rq.req_gnt), 64'(exp_gnt));
      step();
    end
    rq.req_vld = '0;

    // Request stalled in the slot for 5 cycles
    do_reset();
    set_req(3, AEMC_CMD_RD8, 48'h2000, 8'h33);
    #1;
    check("st_gnt3", 64'(rq.req_gnt), 64'h8);
    step();
    rq.req_vld[3] = 1'b0;
    mc.mc_rq_stall = 1'b1;
    set_req(0, AEMC_CMD_WR8, 48'h3000, 8'h44);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("st_vld%0d", k),    64'(mc.mc_rq_vld), 64'd1);
      check($sformatf("st_vadr%0d", k),   64'(mc.mc_rq_vadr), 64'h2000);
      check($sformatf("st_rtnctl%0d", k), 64'(mc.mc_rq_rtnctl), 64'h333);
      check($sformatf("st_gnt%0d", k),    64'(rq.req_gnt), 64'd0);
      step();
    end
    mc.mc_rq_stall = 1'b0;
    #1;
    check("st_release_gnt",  64'(rq.req_gnt), 64'h1);
    check("st_release_vadr", 64'(mc.mc_rq_vadr), 64'h2000);
    step();
    rq.req_vld = '0;
    check("st_next_vadr",   64'(mc.mc_rq_vadr), 64'h3000);
    check("st_next_rtnctl", 64'(mc.mc_rq_rtnctl), 64'h044);
    check("st_next_cmd",    64'(mc.mc_rq_cmd), 64'(AEMC_CMD_WR8));
    step();
    check("st_drained", 64'(mc.mc_rq_vld), 64'd0);

    // Response held for id 2 under rsp_stall
    rq.rsp_stall[2] = 1'b1;
    send_rsp(32'h277, 64'hCAFE_F00D_0000_0002);
    check("rs_vld",        64'(rq.rsp_vld), 64'h4);
    check("rs_tag",        64'(rq.rsp_tag), 64'h77);
    check("rs_stall_pre",  64'(mc.mc_rs_stall), 64'd0);
    step();
    check("rs_stall_on",   64'(mc.mc_rs_stall), 64'd1);
    check("rs_vld_held",   64'(rq.rsp_vld), 64'h4);
    check("rs_data_held",  rq.rsp_data, 64'hCAFE_F00D_0000_0002);
    step();
    check("rs_stall_on2",  64'(mc.mc_rs_stall), 64'd1);
    check("rs_data_held2", rq.rsp_data, 64'hCAFE_F00D_0000_0002);
    rq.rsp_stall[2] = 1'b0;
    step();
    check("rs_delivered",  64'(rq.rsp_vld), 64'd0);
    check("rs_stall_off",  64'(mc.mc_rs_stall), 64'd0);

    // Bad id 6: consumed, credit returned, sticky error
    check("bad_busy", 64'(idle), 64'd0);
    send_rsp(32'h699, 64'h1);
    check("bad_no_rsp", 64'(rq.rsp_vld), 64'd0);
    check("bad_err",    64'(err), 64'd1);
    check("bad_idle",   64'(idle), 64'd1);
    step();
    check("bad_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    step();
    check("rst2_err",      64'(err), 64'd0);
    check("rst2_idle",     64'(idle), 64'd1);
    check("rst2_rq_vld",   64'(mc.mc_rq_vld), 64'd0);
    check("rst2_rsp_vld",  64'(rq.rsp_vld), 64'd0);
    check("rst2_rs_stall", 64'(mc.mc_rs_stall), 64'd0);
    check("rst2_gnt",      64'(rq.req_gnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Credit limit on the MAX_OUTST=2 instance
    rq2.req_vld[0]    = 1'b1;
    rq2.req_cmd[2:0]  = AEMC_CMD_RD8;
    rq2.req_vadr[47:0] = 48'h4000;
    g = 0;
    x = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      g += int'(rq2.req_gnt[0]);
      x += int'(mc2.mc_rq_vld && !mc2.mc_rq_stall);
      step();
    end
    check("cr_grants",    64'(g), 64'd2);
    check("cr_transfers", 64'(x), 64'd2);
    check("cr_gnt_zero",  64'(rq2.req_gnt), 64'd0);
    check("cr_busy",      64'(idle2), 64'd0);
    mc2.mc_rs_vld    = 1'b1;
    mc2.mc_rs_cmd    = 3'd2;
    mc2.mc_rs_rtnctl = 32'h0;
    mc2.mc_rs_data   = 64'h77;
    step();
    mc2.mc_rs_vld    = 1'b0;
    check("cr_rsp_vld", 64'(rq2.rsp_vld), 64'h1);
    g = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      g += int'(rq2.req_gnt[0]);
      step();
    end
    check("cr_one_more", 64'(g), 64'd1);
    rq2.req_vld = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phold_mc_arb.md
Name: phold_mc_arb

Overview:
- Shares the single MC request/response port of one AE memory-controller lane between NUM_REQ phold engine requesters (event-queue core, LP state fetch, GVT writer).
- Round-robin arbitrates requests into one registered MC request slot and tags each request's rtnctl with the requester id.
- Steers returning responses back to the owning requester and throttles issue with an outstanding-request credit counter.
- Sits between the phold cores and the mc_rq_*/mc_rs_* ports of cae_pers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RTNCTL_WIDTH, 32, MC rtnctl width.
- TAG_W, 8, requester-private tag width; requires TAG_W+3 <= RTNCTL_WIDTH.
- MAX_OUTST, 64, maximum MC requests in flight (1..255).

Ports:
- clk  in  1  personality clock.
- rst_n  in  1  synchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_cmd  in  3*NUM_REQ  MC cmd (AEMC_CMD_RD8/WR8 encodings).
- req_scmd  in  4*NUM_REQ  MC sub-command.
- req_size  in  2*NUM_REQ  MC size.
- req_vadr  in  48*NUM_REQ  virtual address.
- req_data  in  64*NUM_REQ  write data.
- req_tag  in  TAG_W*NUM_REQ  requester tag, echoed in the response.
- req_gnt  out  NUM_REQ  one-hot grant; transfer occurs when req_vld[i] && req_gnt[i].
- mc_rq_vld  out  1  MC request valid.
- mc_rq_cmd  out  3  MC request command.
- mc_rq_scmd  out  4  MC request sub-command.
- mc_rq_size  out  2  MC request size.
- mc_rq_vadr  out  48  MC request virtual address.
- mc_rq_data  out  64  MC request write data.
- mc_rq_rtnctl  out  RTNCTL_WIDTH  {zero pad, id[2:0], tag}.
- mc_rq_stall  in  1  MC backpressure.
- mc_rs_vld  in  1  MC response valid.
- mc_rs_cmd  in  3  MC response command.
- mc_rs_scmd  in  4  MC response sub-command.
- mc_rs_data  in  64  MC response data.
- mc_rs_rtnctl  in  RTNCTL_WIDTH  echoed rtnctl.
- mc_rs_stall  out  1  response backpressure to MC.
- rsp_vld  out  NUM_REQ  response valid, one-hot.
- rsp_cmd  out  3  response command, shared bus.
- rsp_data  out  64  response data, shared bus.
- rsp_tag  out  TAG_W  echoed tag, shared bus.
- rsp_stall  in  NUM_REQ  per-requester response backpressure.
- idle  out  1  no held request, no held response, zero outstanding.
- err_bad_id  out  1  sticky flag: response carried id >= NUM_REQ.

Behaviour:
- Reset (rst_n=0 at posedge): mc_rq_vld=0, all rq fields 0, req_gnt=0, rsp_vld=0, rsp buses 0, mc_rs_stall=0, rr pointer=NUM_REQ-1, outstanding=0, err_bad_id=0, idle=1. Reset mid-operation discards held request/response; in-flight MC responses arriving after reset are dropped as bad-id only if id invalid, otherwise delivered normally.
- Request slot: one register. slot_free = !mc_rq_vld || !mc_rq_stall. MC transfer = mc_rq_vld && !mc_rq_stall.
- Credit: issue counter increments on MC transfer and decrements on response acceptance (mc_rs_vld && !mc_rs_stall). Both in the same cycle leave it unchanged. can_grant = slot_free && (outstanding + mc_rq_vld) < MAX_OUTST.
- Arbitration: combinational one-hot grant to the first req_vld at or after ptr+1 (mod NUM_REQ) when can_grant. On grant, ptr <= granted index and the slot loads next cycle; request latency is 1 cycle from grant to mc_rq_vld. With all requesters active, grants rotate 0,1,2,3,0… and no requester waits more than NUM_REQ-1 grants.
- Response path: one holding register. Accept when mc_rs_vld && !mc_rs_stall. id = rtnctl[TAG_W+2:TAG_W]. The next cycle drives rsp_vld[id]=1; the entry is held until !rsp_stall[id].
- mc_rs_stall = held && rsp_stall[held_id] (registered output, 1-cycle late; this is permitted by MC stall slack). Accepting a new response while draining the held one is allowed in the same cycle.
- Bad id: response consumed (credit returned), not delivered, err_bad_id set until reset.
- idle = !mc_rq_vld && !rsp_held && outstanding==0.

Optional Feature:
- PHOLD_MC_ARB_STATS_EN defined: per-requester 32-bit saturating grant counters and a 32-bit stall-cycle counter (mc_rq_vld && mc_rq_stall). Adds ports stat_sel in [2:0] and stat_data out [31:0] (registered, 1-cycle read; sel=NUM_REQ returns the stall counter). All counters clear on reset.
- Undefined: no counters and no stat ports.

Decomposition:
- Shared package phold_pkg: rtnctl field offsets (TAG_LSB, ID_LSB, ID_W=3), MC cmd encodings, and the stats select constant.
- One sub-module: phold_rr_arb (parameterised round-robin one-hot arbiter with pointer update on accept), reusable by the event-queue scheduler.

Test Plan:
- Single requester 1: RD8, vadr=0x1000, tag=0x5A -> mc_rq_vld one cycle after req_gnt, mc_rq_rtnctl=0x0000015A; response with the same rtnctl -> rsp_vld=4'b0010, rsp_tag=0x5A.
- All four requesters continuously valid, no stall -> 8 grants ordered 0,1,2,3,0,1,2,3.
- mc_rq_stall held high 5 cycles with a request in the slot -> mc_rq fields stable, req_gnt=0 throughout, transfer on the first unstalled cycle.
- MAX_OUTST=2, no responses -> exactly 2 transfers then req_gnt=0; one response returns -> exactly one further grant.
- rsp_stall[2]=1 with a response held for id 2 -> mc_rs_stall=1 the next cycle, data stable; release -> delivered, mc_rs_stall drops.
- Response rtnctl id=6 with NUM_REQ=4 -> no rsp_vld, err_bad_id=1, outstanding decremented; then rst_n=0 for 1 cycle -> all outputs at reset values and idle=1.
